envelope_gen: RTL



---
 rtl/envelope_gen_pkg.sv | 17 +
 rtl/envelope_gen_step_timer.sv | 30 +++
 rtl/envelope_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/envelope_gen_pkg.sv
// Shared types and constants for the envelope generator and its gain consumers.
// No logic: states, gain width and unity gain.
// No flow control.
package envelope_gen_pkg;

  localparam int GAIN_W = 8;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'h80;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/envelope_gen_step_timer.sv
// Divides sample_tick by STEP_DIV to produce envelope step strobes.
// step is combinational from sample_tick and the current count (0 cycles).
// No backpressure; clear restarts the division from zero.
module envelope_gen_step_timer #(
  parameter int unsigned STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic clear,
  output logic step
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt;

  assign step = sample_tick && (cnt == LAST);

  // Count ticks 0..STEP_DIV-1; clear and reset force the count back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (sample_tick) begin
      if (cnt == LAST) cnt <= 8'd0;
      else             cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/envelope_gen.sv
// ADSR gain envelope producing the Q1.7 multiple word for the dynamics block.
// Outputs registered; update on the edge that samples a step (1 cycle).
// No backpressure; note strobes take priority over and suppress a coincident step.
module envelope_gen
  import envelope_gen_pkg::*;
#(
  parameter int unsigned STEP_DIV      = 16,
  parameter int unsigned ATTACK_INC    = 16,
  parameter int unsigned DECAY_SHIFT   = 5,
  parameter logic [7:0]  SUSTAIN_LEVEL = 8'h20,
  parameter int unsigned RELEASE_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              note_on,
  input  logic              note_off,
  output logic [GAIN_W-1:0] multiple,
  output logic              active,
  output logic [2:0]        env_state
);

  env_state_t state;
  logic       step;
  logic       off_accepted;
  logic       timer_clear;

  logic [GAIN_W:0]   att_sum;
  logic [GAIN_W-1:0] att_next;
  logic [GAIN_W-1:0] dec_raw;
  logic [GAIN_W-1:0] dec_amt;
  logic [GAIN_W-1:0] dec_next;
  logic [GAIN_W-1:0] rel_raw;
  logic [GAIN_W-1:0] rel_amt;
  logic [GAIN_W-1:0] rel_next;

  // note_off only matters while a note is sounding and not already releasing.
  assign off_accepted = note_off &&
                        (state == ATTACK || state == DECAY || state == SUSTAIN);
  assign timer_clear  = note_on || off_accepted;

  envelope_gen_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .clear      (timer_clear),
    .step       (step)
  );

  // Attack: 9-bit sum so the saturation to unity cannot wrap.
  assign att_sum  = {1'b0, multiple} + 9'(ATTACK_INC);
  assign att_next = (att_sum >= {1'b0, UNITY_GAIN}) ? UNITY_GAIN : att_sum[GAIN_W-1:0];

  // Decay/release: proportional decrement with a floor of one so the curve always moves.
  assign dec_raw  = multiple >> DECAY_SHIFT;
  assign dec_amt  = (dec_raw == '0) ? 8'd1 : dec_raw;
  assign dec_next = (multiple > dec_amt) ? (multiple - dec_amt) : 8'd0;

  assign rel_raw  = multiple >> RELEASE_SHIFT;
  assign rel_amt  = (rel_raw == '0) ? 8'd1 : rel_raw;
  assign rel_next = (multiple > rel_amt) ? (multiple - rel_amt) : 8'd0;

  assign env_state = state;

  // Envelope FSM: reset, then note events, then step-driven gain updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      multiple <= '0;
      active   <= 1'b0;
    end else if (note_on) begin
      // Attack resumes from the current gain to avoid an audible click.
      state  <= ATTACK;
      active <= 1'b1;
    end else if (off_accepted) begin
      state  <= RELEASE;
      active <= 1'b1;
    end else if (step) begin
      case (state)
        ATTACK: begin
          multiple <= att_next;
          if (att_next == UNITY_GAIN) state <= DECAY;
        end
        DECAY: begin
          if (dec_next <= SUSTAIN_LEVEL) begin
            multiple <= SUSTAIN_LEVEL;
            state    <= SUSTAIN;
          end else begin
            multiple <= dec_next;
          end
        end
        RELEASE: begin
          multiple <= rel_next;
          if (rel_next == '0) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
